// File: rtl/design_03_client.sv
// Client FSM that sequences a start/result/check method call to a callee per upstream
// command and returns the captured result/check values downstream, aborting on RDY timeout.
module design_03_client #(
  parameter int WIDTH   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_c,
  input  logic [WIDTH-1:0] cmd_d,
  output logic [WIDTH-1:0] start_a,
  output logic [WIDTH-1:0] start_b,
  output logic             EN_start,
  input  logic             RDY_start,
  output logic [WIDTH-1:0] result_c,
  input  logic [WIDTH-1:0] result,
  input  logic             RDY_result,
  output logic [WIDTH-1:0] check_d,
  input  logic [WIDTH-1:0] check,
  input  logic             RDY_check,
  output logic             EN_check,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_check,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      txn_count
);

  typedef enum logic [2:0] {IDLE, START, WAIT_RES, CHECK, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, rsp_check_q, rsp_check_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       timer_q, timer_d;
  logic [15:0]      txn_count_q, txn_count_d;
  logic             en_start_c, en_check_c;
  logic             rdy_cur, timed_out;

  // The RDY being waited on in the current state; only meaningful in START/WAIT_RES/CHECK.
  always_comb begin
    rdy_cur = 1'b1;
    unique case (state_q)
      START:    rdy_cur = RDY_start;
      WAIT_RES: rdy_cur = RDY_result;
      CHECK:    rdy_cur = RDY_check;
      default:  rdy_cur = 1'b1;
    endcase
  end

  assign timed_out = !rdy_cur && (timer_q == TIMER_LAST);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    rsp_result_d = rsp_result_q;
    rsp_check_d  = rsp_check_q;
    rsp_err_d    = rsp_err_q;
    timer_d      = timer_q;
    txn_count_d  = txn_count_q;
    en_start_c   = 1'b0;
    en_check_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d       = cmd_a;
          b_d       = cmd_b;
          c_d       = cmd_c;
          d_d       = cmd_d;
          rsp_err_d = 1'b0;
          timer_d   = 8'd0;
          state_d   = START;
        end
      end
      START, WAIT_RES, CHECK: begin
        if (rdy_cur) begin
          timer_d = 8'd0;
          if (state_q == START) begin
            en_start_c = 1'b1;
            state_d    = WAIT_RES;
          end else if (state_q == WAIT_RES) begin
            rsp_result_d = result;
            state_d      = CHECK;
          end else begin
            en_check_c  = 1'b1;
            rsp_check_d = check;
            state_d     = RESP;
          end
        end else if (timed_out) begin
          rsp_err_d    = 1'b1;
          rsp_result_d = '0;
          rsp_check_d  = '0;
          timer_d      = 8'd0;
          state_d      = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      rsp_result_q <= '0;
      rsp_check_q  <= '0;
      rsp_err_q    <= 1'b0;
      timer_q      <= 8'd0;
      txn_count_q  <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      rsp_result_q <= rsp_result_d;
      rsp_check_q  <= rsp_check_d;
      rsp_err_q    <= rsp_err_d;
      timer_q      <= timer_d;
      txn_count_q  <= txn_count_d;
    end
  end

  // Enables are gated by RST so an abandoned transaction never fires a method call.
  assign EN_start   = en_start_c && !RST;
  assign EN_check   = en_check_c && !RST;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign start_a    = a_q;
  assign start_b    = b_q;
  assign result_c   = c_q;
  assign check_d    = d_q;
  assign rsp_result = rsp_result_q;
  assign rsp_check  = rsp_check_q;
  assign rsp_err    = rsp_err_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_design_03_client.sv
// Directed bench for design_03_client: nominal flow, stalled start, held response,
// mid-transaction reset, and timeout abort on a TIMEOUT=4 instance.
module tb_design_03_client;

  localparam int W = 7;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] cmd_a, cmd_b, cmd_c, cmd_d, result_v, check_v;

  // Main instance (TIMEOUT=255)
  logic         cmd_valid, rdy_start, rdy_result, rdy_check, rsp_ready;
  logic         cmd_ready, en_start, en_check, rsp_valid, rsp_err, busy;
  logic [W-1:0] start_a, start_b, result_c, check_d, rsp_result, rsp_check;
  logic [15:0]  txn_count;

  // Short-timeout instance (TIMEOUT=4)
  logic         cmd_valid_t, rdy_start_t, rdy_result_t, rdy_check_t, rsp_ready_t;
  logic         cmd_ready_t, en_start_t, en_check_t, rsp_valid_t, rsp_err_t, busy_t;
  logic [W-1:0] start_a_t, start_b_t, result_c_t, check_d_t, rsp_result_t, rsp_check_t;
  logic [15:0]  txn_count_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_check  = 0;
  int n_check_t = 0;

  design_03_client #(.WIDTH(W), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
    .start_a(start_a), .start_b(start_b), .EN_start(en_start), .RDY_start(rdy_start),
    .result_c(result_c), .result(result_v), .RDY_result(rdy_result),
    .check_d(check_d), .check(check_v), .RDY_check(rdy_check), .EN_check(en_check),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_check(rsp_check), .rsp_err(rsp_err),
    .busy(busy), .txn_count(txn_count)
  );

  design_03_client #(.WIDTH(W), .TIMEOUT(4)) dut_t (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
    .start_a(start_a_t), .start_b(start_b_t), .EN_start(en_start_t), .RDY_start(rdy_start_t),
    .result_c(result_c_t), .result(result_v), .RDY_result(rdy_result_t),
    .check_d(check_d_t), .check(check_v), .RDY_check(rdy_check_t), .EN_check(en_check_t),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t),
    .rsp_result(rsp_result_t), .rsp_check(rsp_check_t), .rsp_err(rsp_err_t),
    .busy(busy_t), .txn_count(txn_count_t)
  );

  always #5 CLK = ~CLK;

  // Enable pulses counted mid-cycle, where inputs and state are settled.
  always @(negedge CLK) begin
    if (en_start)   n_start++;
    if (en_check)   n_check++;
    if (en_check_t) n_check_t++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cmd(input logic [W-1:0] a, b, c, d);
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
  endtask

  initial begin
    int base_s, base_c, cnt;
    RST = 1'b1;
    cmd_valid = 0; rdy_start = 1; rdy_result = 1; rdy_check = 1; rsp_ready = 0;
    cmd_valid_t = 0; rdy_start_t = 1; rdy_result_t = 1; rdy_check_t = 1; rsp_ready_t = 0;
    set_cmd(7'h00, 7'h00, 7'h00, 7'h00);
    result_v = 7'h0F; check_v = 7'h33;
    tick(); tick();
    RST = 1'b0;
    #1;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_en_start", en_start, 0);
    check("rst_en_check", en_check, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_start_a", start_a, 0);
    check("rst_rsp_err", rsp_err, 0);

    // Nominal transaction, all RDY high
    base_s = n_start; base_c = n_check;
    set_cmd(7'h05, 7'h0A, 7'h01, 7'h7F);
    cmd_valid = 1;
    #1 check("t1_cmd_ready", cmd_ready, 1);
    tick();                          // accept edge -> START
    cmd_valid = 0;
    check("t1_start_a", start_a, 7'h05);
    check("t1_start_b", start_b, 7'h0A);
    check("t1_result_c", result_c, 7'h01);
    check("t1_check_d", check_d, 7'h7F);
    check("t1_en_start", en_start, 1);
    check("t1_cmd_ready_busy", cmd_ready, 0);
    tick();                          // WAIT_RES
    tick();                          // CHECK
    check("t1_en_check", en_check, 1);
    check("t1_not_valid_early", rsp_valid, 0);
    tick();                          // RESP, 3 edges after accept
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_result", rsp_result, 7'h0F);
    check("t1_rsp_check", rsp_check, 7'h33);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_n_en_start", n_start - base_s, 1);
    check("t1_n_en_check", n_check - base_c, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t1_txn_count", txn_count, 1);
    check("t1_busy_done", busy, 0);

    // Start stalled 10 cycles; enable only in the 11th START cycle
    base_s = n_start;
    rdy_start = 0;
    set_cmd(7'h11, 7'h22, 7'h33, 7'h44);
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    set_cmd(7'h6A, 7'h6B, 7'h6C, 7'h6D);   // operand buses move; latched values must not
    for (int i = 0; i < 10; i++) begin
      check("t2_en_start_low", en_start, 0);
      check("t2_start_a_hold", start_a, 7'h11);
      tick();
    end
    check("t2_start_b_hold", start_b, 7'h22);
    rdy_start = 1;
    #1 check("t2_en_start_11th", en_start, 1);
    tick(); tick(); tick();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_n_en_start", n_start - base_s, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t2_txn_count", txn_count, 2);

    // Response held 5 cycles with a new command pending
    set_cmd(7'h01, 7'h02, 7'h03, 7'h04);
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    tick(); tick(); tick();
    check("t3_rsp_valid", rsp_valid, 1);
    cmd_valid = 1;
    set_cmd(7'h09, 7'h08, 7'h07, 7'h06);
    result_v = 7'h55; check_v = 7'h44;
    for (int i = 0; i < 5; i++) begin
      check("t3_cmd_ready_low", cmd_ready, 0);
      check("t3_rsp_result_hold", rsp_result, 7'h0F);
      check("t3_rsp_check_hold", rsp_check, 7'h33);
      check("t3_start_a_hold", start_a, 7'h01);
      tick();
    end
    rsp_ready = 1;
    tick();                          // handshake -> IDLE
    rsp_ready = 0;
    check("t3_txn_count", txn_count, 3);
    check("t3_cmd_ready_idle", cmd_ready, 1);
    tick();                          // accept pending command
    cmd_valid = 0;
    check("t3_new_start_a", start_a, 7'h09);
    tick(); tick(); tick();
    check("t3_new_rsp_result", rsp_result, 7'h55);
    check("t3_new_rsp_check", rsp_check, 7'h44);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t3_txn_count2", txn_count, 4);

    // Reset while in CHECK with RDY_check rising that same cycle
    base_c = n_check;
    rdy_check = 0;
    set_cmd(7'h12, 7'h34, 7'h56, 7'h78);
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    tick(); tick();                  // now in CHECK, waiting
    check("t4_in_check_busy", busy, 1);
    rdy_check = 1;
    RST = 1;
    #1 check("t4_en_check_gated", en_check, 0);
    tick();
    RST = 0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_start_a", start_a, 0);
    check("t4_rsp_result", rsp_result, 0);
    check("t4_txn_count", txn_count, 0);
    check("t4_n_en_check", n_check - base_c, 0);

    // Timeout instance: a normal transaction first so the payload is non-zero
    set_cmd(7'h0C, 7'h0D, 7'h0E, 7'h0F);
    cmd_valid_t = 1;
    tick();
    cmd_valid_t = 0;
    tick(); tick(); tick();
    check("t5_normal_rsp_result", rsp_result_t, 7'h55);
    rsp_ready_t = 1;
    tick();
    rsp_ready_t = 0;

    base_c = n_check_t;
    rdy_result_t = 0;
    cmd_valid_t = 1;
    tick();                          // START
    cmd_valid_t = 0;
    tick();                          // enter WAIT_RES
    cnt = 0;
    while (!rsp_valid_t && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t5_wait_res_cycles", cnt, 4);
    check("t5_rsp_valid", rsp_valid_t, 1);
    check("t5_rsp_err", rsp_err_t, 1);
    check("t5_rsp_result_zero", rsp_result_t, 0);
    check("t5_rsp_check_zero", rsp_check_t, 0);
    check("t5_no_en_check", n_check_t - base_c, 0);
    rdy_result_t = 1;
    rsp_ready_t = 1;
    tick();
    rsp_ready_t = 0;
    check("t5_txn_count_err", txn_count_t, 2);
    cmd_valid_t = 1;
    tick();
    cmd_valid_t = 0;
    check("t5_err_cleared", rsp_err_t, 0);
    tick(); tick(); tick();
    check("t5_recover_valid", rsp_valid_t, 1);
    check("t5_recover_err", rsp_err_t, 0);
    rsp_ready_t = 1;
    tick();
    rsp_ready_t = 0;
    check("t5_txn_count_final", txn_count_t, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/design_03_client.md
DESIGN_03_CLIENT -- requirements
Module: design_03_client

Interface
REQ-001 Parameter: WIDTH, 7, data width of all operand and result buses.
REQ-002 Parameter: TIMEOUT, 255, max cycles waiting on any callee RDY before abort (legal range 1..255).
REQ-003 Single clock and reset: CLK input, RST input; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  upstream command present.
REQ-007 cmd_ready  out  1  client can accept a command.
REQ-008 cmd_a, cmd_b, cmd_c, cmd_d  in  WIDTH each  operands for start a/b, result c, check d.
REQ-009 start_a, start_b  out  WIDTH each  start method arguments to callee.
REQ-010 EN_start  out  1  start method enable.
REQ-011 RDY_start  in  1  callee start ready.
REQ-012 result_c  out  WIDTH  result method argument.
REQ-013 result  in  WIDTH  callee result value.
REQ-014 RDY_result  in  1  result valid.
REQ-015 check_d  out  WIDTH  check method argument.
REQ-016 check  in  WIDTH  callee check value.
REQ-017 RDY_check  in  1  check ready.
REQ-018 EN_check  out  1  check method enable.
REQ-019 rsp_valid  out  1; rsp_ready  in  1  downstream response handshake.
REQ-020 rsp_result, rsp_check  out  WIDTH each; rsp_err  out  1  response payload.
REQ-021 busy  out  1  state != IDLE; txn_count  out  16  completed responses.

Function
REQ-022 FSM states SHALL be IDLE, START, WAIT_RES, CHECK, RESP; one transition max per cycle.
REQ-023 IDLE: cmd_ready=1; on cmd_valid, latch a/b/c/d into operand registers, go START next cycle.
REQ-024 start_a/start_b/result_c/check_d SHALL be driven from latched registers at all times (0 after reset).
REQ-025 START: EN_start = RDY_start combinationally; cycle with RDY_start=1 -> WAIT_RES; EN_start SHALL be exactly one cycle per transaction.
REQ-026 WAIT_RES: first cycle with RDY_result=1, capture result into rsp_result -> CHECK.
REQ-027 CHECK: EN_check = RDY_check; cycle with RDY_check=1 captures check into rsp_check -> RESP; exactly one EN_check pulse per transaction.
REQ-028 EN_start/EN_check SHALL never assert while corresponding RDY is 0 or outside their state.
REQ-029 Wait timer (8-bit) clears on every state entry, increments each cycle in START/WAIT_RES/CHECK while RDY low.
REQ-030 If timer reaches TIMEOUT-1 with RDY still low: go RESP, rsp_err=1, rsp_result=rsp_check=0, no enable pulsed that cycle.
REQ-031 RESP: rsp_valid=1, payload stable; on rsp_ready go IDLE, txn_count += 1 (wraps 0xFFFF->0x0000), errored transactions included.
REQ-032 rsp_err SHALL clear on next command accept.
REQ-033 Minimum latency cmd accept -> rsp_valid: 3 cycles (RDY_* all high).
REQ-034 cmd_ready SHALL be 0 outside IDLE; no command queueing.

Reset
REQ-035 RST=1 at a clock edge: state=IDLE, all operand/payload registers 0, rsp_err=0, timer=0, txn_count=0.
REQ-036 Reset outputs: cmd_ready=1, EN_start=0, EN_check=0, rsp_valid=0, busy=0.
REQ-037 RST mid-transaction SHALL abandon it without any enable pulse in the reset cycle; no response emitted.

Verification
REQ-038 All RDY high, cmd a=0x05 b=0x0A c=0x01 d=0x7F, result=0x0F, check=0x33 -> single EN_start, single EN_check, rsp_valid 3 cycles after accept, rsp_result=0x0F rsp_check=0x33 rsp_err=0, txn_count=1.
REQ-039 RDY_start low 10 cycles then high -> EN_start only in 11th START cycle, operands held stable throughout.
REQ-040 TIMEOUT=4, RDY_result held low -> RESP after 4 WAIT_RES cycles, rsp_err=1, payload 0, EN_check never asserted.
REQ-041 rsp_ready held low 5 cycles with new cmd_valid asserted -> cmd_ready=0, payload stable, accept only after handshake.
REQ-042 RST asserted in CHECK with RDY_check=1 -> EN_check=0 that cycle, next cycle IDLE, all outputs at reset values.
REQ-043 txn_count preloaded via 65536 transactions -> wraps to 0x0000.
